// File: rtl/mnist_pattern_streamer.sv
// mnist_pattern_streamer: replays stored frames byte-per-cycle into a classifier and
// filters its captured outputs into a debounced valid/stable result.
`default_nettype none

module mnist_pattern_streamer #(
  parameter int NUM_PATTERNS    = 4,
  parameter int BYTES_PER_FRAME = 32,
  parameter int DWELL_CYCLES    = 6000000,
  parameter int LATCH_OFFSET    = 1,
  parameter int STABLE_FRAMES   = 3,
  parameter int DISCARD_FRAMES  = 1
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          mode_auto,
  input  logic                                          sel_next,
  input  logic                                          pat_wr_en,
  input  logic [$clog2(NUM_PATTERNS*BYTES_PER_FRAME)-1:0] pat_wr_addr,
  input  logic [7:0]                                    pat_wr_data,
  input  logic [3:0]                                    dut_index,
  input  logic [7:0]                                    dut_value,
  output logic [7:0]                                    stream_byte,
  output logic                                          frame_start,
  output logic [$clog2(NUM_PATTERNS)-1:0]               pattern_id,
  output logic [3:0]                                    result_index,
  output logic [7:0]                                    result_value,
  output logic                                          result_valid,
  output logic                                          result_stable
);

  localparam int AW = $clog2(NUM_PATTERNS*BYTES_PER_FRAME);
  localparam int SW = $clog2(BYTES_PER_FRAME);
  localparam int PW = $clog2(NUM_PATTERNS);
  localparam int DW = $clog2(DWELL_CYCLES+1);
  localparam int CW = $clog2(STABLE_FRAMES+1);
  localparam int XW = $clog2(DISCARD_FRAMES+2);
  localparam logic [PW-1:0] LAST_PID = PW'(NUM_PATTERNS-1);

  logic [7:0]    mem_q [NUM_PATTERNS*BYTES_PER_FRAME];

  logic [SW-1:0] slot_q,    slot_d;
  logic [DW-1:0] dwell_q,   dwell_d;
  logic          pend_q,    pend_d;
  logic [PW-1:0] pid_q,     pid_d;
  logic [7:0]    sbyte_q;
  logic          fstart_q;
  logic [3:0]    ridx_q,    ridx_d;
  logic [7:0]    rval_q,    rval_d;
  logic          rvalid_q,  rvalid_d;
  logic          rstable_q, rstable_d;
  logic [CW-1:0] scnt_q,    scnt_d;
  logic [XW-1:0] disc_q,    disc_d;
  logic          sel_q;

  logic          wrap, dwell_hit, sel_rise, req, switch_now, cap;
  logic [AW-1:0] rd_addr;

  // Byte count is a power of two, so the frame address is a plain concatenation.
  assign rd_addr = {pid_q, slot_q};

  always_comb begin
    wrap       = (slot_q == SW'(BYTES_PER_FRAME-1));
    dwell_hit  = mode_auto && !pend_q && (dwell_q == DW'(DWELL_CYCLES-1));
    sel_rise   = sel_next && !sel_q;
    req        = mode_auto ? dwell_hit : sel_rise;
    switch_now = wrap && pend_q;
    cap        = (slot_q == SW'(LATCH_OFFSET));

    slot_d = slot_q + 1'b1;

    // Dwell restarts from the switch itself: the count idles at zero while a
    // switch waits for the frame boundary, so each dwell is a whole number of frames.
    if (!mode_auto || pend_q || dwell_hit) dwell_d = '0;
    else                                   dwell_d = dwell_q + 1'b1;

    pend_d = switch_now ? req : (pend_q || req);

    pid_d = pid_q;
    if (switch_now) pid_d = (pid_q == LAST_PID) ? '0 : pid_q + 1'b1;

    ridx_d    = ridx_q;
    rval_d    = rval_q;
    rvalid_d  = rvalid_q;
    rstable_d = rstable_q;
    scnt_d    = scnt_q;
    disc_d    = disc_q;

    if (switch_now) begin
      rvalid_d  = 1'b0;
      rstable_d = 1'b0;
      scnt_d    = '0;
      disc_d    = '0;
    end else if (cap) begin
      if (disc_q < XW'(DISCARD_FRAMES)) begin
        disc_d = disc_q + 1'b1;
      end else begin
        ridx_d   = dut_index;
        rval_d   = dut_value;
        rvalid_d = 1'b1;
        if (rvalid_q && (dut_index == ridx_q))
          scnt_d = (scnt_q == CW'(STABLE_FRAMES)) ? scnt_q : scnt_q + 1'b1;
        else
          scnt_d = CW'(1);
        rstable_d = (scnt_d == CW'(STABLE_FRAMES));
      end
    end
  end

  // Frame memory survives reset; nonblocking write gives read-old-data on collision.
  always_ff @(posedge clk) begin
    if (pat_wr_en) mem_q[pat_wr_addr] <= pat_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q    <= '0;
      dwell_q   <= '0;
      pend_q    <= 1'b0;
      pid_q     <= '0;
      sbyte_q   <= '0;
      fstart_q  <= 1'b0;
      ridx_q    <= '0;
      rval_q    <= '0;
      rvalid_q  <= 1'b0;
      rstable_q <= 1'b0;
      scnt_q    <= '0;
      disc_q    <= '0;
      sel_q     <= 1'b0;
    end else begin
      slot_q    <= slot_d;
      dwell_q   <= dwell_d;
      pend_q    <= pend_d;
      pid_q     <= pid_d;
      sbyte_q   <= mem_q[rd_addr];
      fstart_q  <= (slot_q == '0);
      ridx_q    <= ridx_d;
      rval_q    <= rval_d;
      rvalid_q  <= rvalid_d;
      rstable_q <= rstable_d;
      scnt_q    <= scnt_d;
      disc_q    <= disc_d;
      sel_q     <= sel_next;
    end
  end

  assign stream_byte   = sbyte_q;
  assign frame_start   = fstart_q;
  assign pattern_id    = pid_q;
  assign result_index  = ridx_q;
  assign result_value  = rval_q;
  assign result_valid  = rvalid_q;
  assign result_stable = rstable_q;

endmodule

`default_nettype wire

// File: tb/tb_mnist_pattern_streamer.sv
// Bench for mnist_pattern_streamer: stream-byte scoreboard plus switching,
// stability, collision and asynchronous-reset checks.
`default_nettype none

module tb_mnist_pattern_streamer;

  logic       clk;
  logic       rst_n;
  logic       mode_auto;
  logic       sel_next;
  logic       pat_wr_en;
  logic [6:0] pat_wr_addr;
  logic [7:0] pat_wr_data;
  logic [3:0] dut_index;
  logic [7:0] dut_value;
  logic [7:0] stream_byte;
  logic       frame_start;
  logic [1:0] pattern_id;
  logic [3:0] result_index;
  logic [7:0] result_value;
  logic       result_valid;
  logic       result_stable;

  mnist_pattern_streamer #(
    .NUM_PATTERNS(4), .BYTES_PER_FRAME(32), .DWELL_CYCLES(100),
    .LATCH_OFFSET(1), .STABLE_FRAMES(3), .DISCARD_FRAMES(1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .mode_auto(mode_auto), .sel_next(sel_next),
    .pat_wr_en(pat_wr_en), .pat_wr_addr(pat_wr_addr), .pat_wr_data(pat_wr_data),
    .dut_index(dut_index), .dut_value(dut_value),
    .stream_byte(stream_byte), .frame_start(frame_start), .pattern_id(pattern_id),
    .result_index(result_index), .result_value(result_value),
    .result_valid(result_valid), .result_stable(result_stable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         jn      = 0;
  int         pid_m   = 0;
  bit         adv_pend = 1'b0;
  bit         sb_on    = 1'b0;
  logic [7:0] mem_m [128];
  logic [7:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, jn);
    end
  endtask

  // One clock: push the byte addressed this cycle, advance, pop and compare.
  task automatic tick();
    int s;
    logic [7:0] e;
    s = jn % 32;
    if (sb_on) exp_q.push_back(mem_m[pid_m*32 + s]);
    if (pat_wr_en) mem_m[pat_wr_addr] = pat_wr_data;
    if (s == 31 && adv_pend) begin
      pid_m    = (pid_m + 1) % 4;
      adv_pend = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    jn++;
    if (sb_on) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("stream_byte", stream_byte, e);
      end
      check_eq("frame_start", frame_start, ((jn - 1) % 32) == 0);
      check_eq("pattern_id", pattern_id, pid_m);
    end
  endtask

  task automatic run_to(input int s);
    for (int i = 0; i < 32 && (jn % 32) != s; i++) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_byte"},   stream_byte,   0);
    check_eq({tag, "_fstart"}, frame_start,   0);
    check_eq({tag, "_pid"},    pattern_id,    0);
    check_eq({tag, "_ridx"},   result_index,  0);
    check_eq({tag, "_rval"},   result_value,  0);
    check_eq({tag, "_valid"},  result_valid,  0);
    check_eq({tag, "_stable"}, result_stable, 0);
  endtask

  // After release: first capture (slot 1) dropped, second accepted.
  task automatic post_reset_run(input logic [3:0] idx);
    for (int i = 0; i < 64; i++) begin
      tick();
      if (jn == 2)  check_eq("rst_discard", result_valid, 0);
      if (jn == 34) begin
        check_eq("rst_accept_valid", result_valid, 1);
        check_eq("rst_accept_idx",   result_index, idx);
      end
    end
  endtask

  initial begin
    int cur;
    int changes;
    int last_t;
    rst_n = 1'b0; mode_auto = 1'b0; sel_next = 1'b0;
    pat_wr_en = 1'b0; pat_wr_addr = '0; pat_wr_data = '0;
    dut_index = '0; dut_value = '0;
    for (int i = 0; i < 128; i++) mem_m[i] = 8'h00;
    repeat (2) @(negedge clk);
    check_all_zero("reset");

    // Load frame memory during reset: pattern p byte k holds p*32+k.
    for (int i = 0; i < 128; i++) begin
      pat_wr_en = 1'b1; pat_wr_addr = 7'(i); pat_wr_data = 8'(i);
      tick();
    end
    pat_wr_en = 1'b0;
    tick();
    check_eq("reset_hold_byte", stream_byte, 0);

    rst_n = 1'b1; jn = 0; sb_on = 1'b1;
    post_reset_run(4'd0);

    // Write collision on the byte being read this cycle.
    run_to(5);
    pat_wr_en = 1'b1; pat_wr_addr = 7'd5; pat_wr_data = 8'hAA;
    tick();
    pat_wr_en = 1'b0;
    repeat (40) tick();

    // Manual switch followed by stability tracking on index 7.
    dut_index = 4'd7; dut_value = 8'h55;
    run_to(10);
    sel_next = 1'b1; adv_pend = 1'b1;
    tick();
    sel_next = 1'b0;
    run_to(31); tick();
    run_to(2);
    check_eq("stab_cap1_valid", result_valid, 0);
    tick(); run_to(2);
    check_eq("stab_cap2_valid",  result_valid,  1);
    check_eq("stab_cap2_idx",    result_index,  7);
    check_eq("stab_cap2_val",    result_value,  8'h55);
    check_eq("stab_cap2_stable", result_stable, 0);
    tick(); run_to(2);
    check_eq("stab_cap3_stable", result_stable, 0);
    tick(); run_to(2);
    check_eq("stab_cap4_stable", result_stable, 1);
    dut_index = 4'd2;
    tick(); run_to(2);
    check_eq("chg_stable", result_stable, 0);
    check_eq("chg_idx",    result_index,  2);
    check_eq("chg_valid",  result_valid,  1);
    tick(); run_to(2);
    check_eq("chg_cnt2_stable", result_stable, 0);
    tick(); run_to(2);
    check_eq("chg_cnt3_stable", result_stable, 1);

    // Three pulses in one frame give a single advance.
    run_to(4);
    adv_pend = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sel_next = 1'b1; tick();
      sel_next = 1'b0; tick();
    end
    run_to(31); tick();
    repeat (40) tick();
    check_eq("man3_pid", pattern_id, 2);

    // Held request advances once only.
    run_to(5);
    sel_next = 1'b1; adv_pend = 1'b1;
    repeat (100) tick();
    check_eq("hold_pid", pattern_id, 3);
    sel_next = 1'b0;
    tick();

    // Auto mode: 3 -> 0,1,2,3,0, switches at frame start, 128-cycle dwells.
    sb_on = 1'b0; exp_q.delete();
    mode_auto = 1'b1;
    cur = 3; changes = 0; last_t = -1;
    for (int i = 0; i < 1200 && changes < 5; i++) begin
      sel_next = (i == 20);
      tick();
      if (pattern_id != 2'(cur)) begin
        check_eq("auto_slot", jn % 32, 0);
        check_eq("auto_seq", pattern_id, (cur + 1) % 4);
        if (last_t >= 0) check_eq("auto_dwell", jn - last_t, 128);
        last_t = jn;
        cur = (cur + 1) % 4;
        changes++;
      end
    end
    check_eq("auto_changes", changes, 5);
    mode_auto = 1'b0; sel_next = 1'b0;
    pid_m = cur; sb_on = 1'b1;
    repeat (33) tick();

    // Asynchronous mid-frame reset, then memory readback.
    run_to(17);
    check_eq("pre_rst_byte", stream_byte, 16);
    sb_on = 1'b0; exp_q.delete();
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1; jn = 0; pid_m = 0; adv_pend = 1'b0; sb_on = 1'b1;
    post_reset_run(4'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
